payload_receiver: RTL and testbench

- Receive-side counterpart of the packet transmitter used over the UART link.
- Consumes bytes from the UART RX core, discards bytes until it sees header byte EVENT_CODE, then assembles exactly RECV_BYTES_QTD payload bytes into a wide buffer.
- Publishes the buffer atomically with a one-cycle completion pulse.
- Aborts a packet with an error pulse if the inter-byte gap exceeds a timeout.

---
 rtl/payload_receiver.sv | 133 +++++++++++++
 tb/tb_payload_receiver.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_receiver.sv
// UART payload receiver: waits for a header byte, assembles a fixed-length payload and
// publishes it atomically; aborts a partial packet when the inter-byte gap gets too long.
module payload_receiver #(
    parameter logic [7:0]  EVENT_CODE     = 8'hAD,
    parameter int unsigned RECV_BYTES_QTD = 41,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CICLOS = 50000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        dado_recebido_valido,
    input  logic [7:0]                  dado_entrada,
    output logic [RECV_BYTES_QTD*8-1:0] buffer_recebido,
    output logic                        recepcao_concluida,
    output logic                        erro_timeout,
    output logic                        recebendo,
    output logic [7:0]                  contador_pacotes
);

    localparam int unsigned IdxW = (RECV_BYTES_QTD > 1) ? $clog2(RECV_BYTES_QTD) : 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CICLOS);
    localparam int unsigned BufW = RECV_BYTES_QTD * 8;

    localparam logic [IdxW-1:0] UltimoIdx = IdxW'(RECV_BYTES_QTD - 1);
    localparam logic [ToW-1:0]  LimiteTo  = ToW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [0:0] {
        StEsperaCabecalho,
        StRecebeDados
    } estado_e;

    estado_e          estado_q, estado_d;
    logic [IdxW-1:0]  indice_q, indice_d;
    logic [ToW-1:0]   timeout_q, timeout_d;
    logic [BufW-1:0]  montagem_q, montagem_d;
    logic [BufW-1:0]  montagem_escrita;
    logic [BufW-1:0]  buffer_q, buffer_d;
    logic [7:0]       contador_q, contador_d;
    logic             concluida_q, concluida_d;
    logic             erro_q, erro_d;

    // Assembly register with the incoming byte merged at the current payload position.
    always_comb begin
        montagem_escrita = montagem_q;
        for (int unsigned i = 0; i < RECV_BYTES_QTD; i++) begin
            if (indice_q == IdxW'(i)) begin
                if (MSB_FIRST) begin
                    montagem_escrita[(RECV_BYTES_QTD - 1 - i) * 8 +: 8] = dado_entrada;
                end else begin
                    montagem_escrita[i * 8 +: 8] = dado_entrada;
                end
            end
        end
    end

    always_comb begin
        estado_d    = estado_q;
        indice_d    = indice_q;
        timeout_d   = timeout_q;
        montagem_d  = montagem_q;
        buffer_d    = buffer_q;
        contador_d  = contador_q;
        concluida_d = 1'b0;
        erro_d      = 1'b0;

        unique case (estado_q)
            StEsperaCabecalho: begin
                if (dado_recebido_valido && (dado_entrada == EVENT_CODE)) begin
                    estado_d  = StRecebeDados;
                    indice_d  = '0;
                    timeout_d = '0;
                end
            end

            StRecebeDados: begin
                // A strobe always wins over an expiring timeout.
                if (dado_recebido_valido) begin
                    montagem_d = montagem_escrita;
                    timeout_d  = '0;
                    indice_d   = indice_q + IdxW'(1);
                    if (indice_q == UltimoIdx) begin
                        buffer_d    = montagem_escrita;
                        contador_d  = contador_q + 8'd1;
                        concluida_d = 1'b1;
                        estado_d    = StEsperaCabecalho;
                        indice_d    = '0;
                    end
                end else begin
                    timeout_d = timeout_q + ToW'(1);
                    if (timeout_d == LimiteTo) begin
                        estado_d  = StEsperaCabecalho;
                        erro_d    = 1'b1;
                        timeout_d = '0;
                        indice_d  = '0;
                    end
                end
            end

            default: begin
                estado_d = StEsperaCabecalho;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= StEsperaCabecalho;
            indice_q    <= '0;
            timeout_q   <= '0;
            montagem_q  <= '0;
            buffer_q    <= '0;
            contador_q  <= '0;
            concluida_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            indice_q    <= indice_d;
            timeout_q   <= timeout_d;
            montagem_q  <= montagem_d;
            buffer_q    <= buffer_d;
            contador_q  <= contador_d;
            concluida_q <= concluida_d;
            erro_q      <= erro_d;
        end
    end

    assign buffer_recebido    = buffer_q;
    assign recepcao_concluida = concluida_q;
    assign erro_timeout       = erro_q;
    assign recebendo          = (estado_q == StRecebeDados);
    assign contador_pacotes   = contador_q;

endmodule

// File: tb/tb_payload_receiver.sv
// Bench for payload_receiver: MSB-first and LSB-first builds share one stimulus stream and
// are checked against a packet-level reference model.
module tb_payload_receiver;

    localparam int unsigned N  = 4;
    localparam int unsigned T  = 20;
    localparam int unsigned W  = N * 8;
    localparam logic [7:0]  EV = 8'hAD;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         valido = 1'b0;
    logic [7:0]   dado = 8'h00;

    logic [W-1:0] buf_m, buf_l;
    logic         concl_m, concl_l, err_m, err_l, rec_m, rec_l;
    logic [7:0]   cnt_m, cnt_l;

    always #5 clock = ~clock;

    payload_receiver #(
        .EVENT_CODE    (EV),
        .RECV_BYTES_QTD(N),
        .MSB_FIRST     (1'b1),
        .TIMEOUT_CICLOS(T)
    ) dut_m (
        .clock               (clock),
        .reset               (reset),
        .dado_recebido_valido(valido),
        .dado_entrada        (dado),
        .buffer_recebido     (buf_m),
        .recepcao_concluida  (concl_m),
        .erro_timeout        (err_m),
        .recebendo           (rec_m),
        .contador_pacotes    (cnt_m)
    );

    payload_receiver #(
        .EVENT_CODE    (EV),
        .RECV_BYTES_QTD(N),
        .MSB_FIRST     (1'b0),
        .TIMEOUT_CICLOS(T)
    ) dut_l (
        .clock               (clock),
        .reset               (reset),
        .dado_recebido_valido(valido),
        .dado_entrada        (dado),
        .buffer_recebido     (buf_l),
        .recepcao_concluida  (concl_l),
        .erro_timeout        (err_l),
        .recebendo           (rec_l),
        .contador_pacotes    (cnt_l)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: packet in progress, bytes collected so far, idle gap length.
    bit           m_in_pkt = 1'b0;
    byte unsigned m_bytes[$];
    int           m_gap = 0;
    logic [W-1:0] m_buf_m = '0;
    logic [W-1:0] m_buf_l = '0;
    logic [7:0]   m_cnt = 8'd0;
    int           m_concl_n = 0;
    int           m_err_n = 0;

    // Observed pulse totals across both builds.
    int o_concl_m = 0, o_concl_l = 0, o_err_m = 0, o_err_l = 0, o_both = 0;

    task automatic model_step(input bit stb, input logic [7:0] d);
        if (!m_in_pkt) begin
            if (stb && d == EV) begin
                m_in_pkt = 1'b1;
                m_bytes.delete();
                m_gap = 0;
            end
        end else if (stb) begin
            m_bytes.push_back(d);
            m_gap = 0;
            if (m_bytes.size() == N) begin
                m_buf_m = '0;
                m_buf_l = '0;
                foreach (m_bytes[i]) begin
                    m_buf_m = (m_buf_m << 8) | W'(m_bytes[i]);
                    m_buf_l = m_buf_l | (W'(m_bytes[i]) << (8 * i));
                end
                m_cnt = m_cnt + 8'd1;
                m_concl_n++;
                m_in_pkt = 1'b0;
            end
        end else begin
            m_gap++;
            if (m_gap == T - 1) begin
                m_in_pkt = 1'b0;
                m_err_n++;
            end
        end
    endtask

    task automatic tick(input bit stb, input logic [7:0] d);
        @(negedge clock);
        valido = stb;
        dado   = d;
        model_step(stb, d);
        @(posedge clock);
        #1;
        valido = 1'b0;
        o_concl_m += int'(concl_m);
        o_concl_l += int'(concl_l);
        o_err_m   += int'(err_m);
        o_err_l   += int'(err_l);
        if ((concl_m && err_m) || (concl_l && err_l)) o_both++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom));
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clock);
        reset  = 1'b1;
        valido = 1'b0;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        reset    = 1'b0;
        m_in_pkt = 1'b0;
        m_bytes.delete();
        m_gap    = 0;
        m_buf_m  = '0;
        m_buf_l  = '0;
        m_cnt    = 8'd0;
    endtask

    task automatic test_reset();
        apply_reset(3);
        n_vec++;
        if (buf_m !== '0 || buf_l !== '0) begin
            n_err++;
            $display("FAIL reset_buf: got %h/%h expected 0", buf_m, buf_l);
        end
        n_vec++;
        if ({concl_m, concl_l, err_m, err_l, rec_m, rec_l} !== 6'b0 || cnt_m !== 8'd0
            || cnt_l !== 8'd0) begin
            n_err++;
            $display("FAIL reset_flags: got concl %b%b err %b%b rec %b%b cnt %0d/%0d expected 0",
                     concl_m, concl_l, err_m, err_l, rec_m, rec_l, cnt_m, cnt_l);
        end
        tick(1'b1, 8'h11);
        n_vec++;
        if (rec_m !== 1'b0 || rec_l !== 1'b0) begin
            n_err++;
            $display("FAIL junk_ignored: got recebendo %b/%b expected 0", rec_m, rec_l);
        end
    endtask

    task automatic test_spaced_packet();
        logic [7:0] pl[4];
        int c0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        c0 = o_concl_m;
        tick(1'b1, EV);
        n_vec++;
        if (rec_m !== 1'b1 || rec_l !== 1'b1) begin
            n_err++;
            $display("FAIL rec_after_header: got %b/%b expected 1", rec_m, rec_l);
        end
        for (int i = 0; i < 4; i++) begin
            idle(4);
            tick(1'b1, pl[i]);
        end
        n_vec++;
        if (buf_m !== 32'h11223344 || buf_l !== 32'h44332211) begin
            n_err++;
            $display("FAIL spaced_buf: got %h/%h expected 11223344/44332211", buf_m, buf_l);
        end
        n_vec++;
        if (concl_m !== 1'b1 || cnt_m !== 8'd1 || rec_m !== 1'b0 || cnt_l !== 8'd1) begin
            n_err++;
            $display("FAIL spaced_done: got concl %b cnt %0d/%0d rec %b expected 1 1/1 0",
                     concl_m, cnt_m, cnt_l, rec_m);
        end
        idle(1);
        n_vec++;
        if (concl_m !== 1'b0 || (o_concl_m - c0) != 1) begin
            n_err++;
            $display("FAIL pulse_width: got concl %b pulses %0d expected 0 and 1",
                     concl_m, o_concl_m - c0);
        end
    endtask

    task automatic test_junk_back_to_back();
        logic [7:0] st[8];
        int c0;
        st = '{8'h00, 8'hFF, 8'h12, EV, 8'h01, 8'h02, 8'h03, 8'h04};
        c0 = o_concl_m;
        foreach (st[i]) tick(1'b1, st[i]);
        idle(2);
        n_vec++;
        if (buf_m !== 32'h01020304 || buf_l !== 32'h04030201) begin
            n_err++;
            $display("FAIL junk_buf: got %h/%h expected 01020304/04030201", buf_m, buf_l);
        end
        n_vec++;
        if ((o_concl_m - c0) != 1) begin
            n_err++;
            $display("FAIL junk_pulses: got %0d expected 1", o_concl_m - c0);
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] prev;
        logic [7:0] pcnt;
        int e0;
        logic [7:0] pl[4];
        prev = buf_m;
        pcnt = cnt_m;
        e0   = o_err_m;
        tick(1'b1, EV);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        idle(T - 2);
        n_vec++;
        if ((o_err_m - e0) != 0 || rec_m !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_early: got errs %0d rec %b expected 0 1", o_err_m - e0, rec_m);
        end
        idle(1);
        n_vec++;
        if (err_m !== 1'b1 || err_l !== 1'b1 || rec_m !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse: got err %b/%b rec %b expected 1/1 0",
                     err_m, err_l, rec_m);
        end
        idle(2);
        n_vec++;
        if ((o_err_m - e0) != 1 || buf_m !== prev || cnt_m !== pcnt) begin
            n_err++;
            $display("FAIL timeout_hold: got errs %0d buf %h cnt %0d expected 1 %h %0d",
                     o_err_m - e0, buf_m, cnt_m, prev, pcnt);
        end
        pl = '{EV, 8'hAA, 8'hBB, 8'hCC};
        foreach (pl[i]) tick(1'b1, pl[i]);
        tick(1'b1, 8'hDD);
        n_vec++;
        if (buf_m !== 32'hAABBCCDD || buf_l !== 32'hDDCCBBAA) begin
            n_err++;
            $display("FAIL after_timeout_buf: got %h/%h expected AABBCCDD/DDCCBBAA",
                     buf_m, buf_l);
        end
    endtask

    task automatic test_timeout_boundary();
        int e0;
        e0 = o_err_m + o_err_l;
        tick(1'b1, EV);
        tick(1'b1, 8'h11);
        idle(T - 2);
        tick(1'b1, 8'h22);
        n_vec++;
        if ((o_err_m + o_err_l - e0) != 0 || rec_m !== 1'b1) begin
            n_err++;
            $display("FAIL boundary_accept: got errs %0d rec %b expected 0 1",
                     o_err_m + o_err_l - e0, rec_m);
        end
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        n_vec++;
        if (buf_m !== 32'h11223344 || buf_l !== 32'h44332211) begin
            n_err++;
            $display("FAIL boundary_buf: got %h/%h expected 11223344/44332211", buf_m, buf_l);
        end
    endtask

    task automatic test_header_payload_and_reset();
        int c0, e0;
        for (int i = 0; i < 5; i++) tick(1'b1, EV);
        n_vec++;
        if (buf_m !== 32'hADADADAD || buf_l !== 32'hADADADAD) begin
            n_err++;
            $display("FAIL header_as_payload: got %h/%h expected ADADADAD", buf_m, buf_l);
        end
        tick(1'b1, EV);
        tick(1'b1, 8'h11);
        apply_reset(1);
        c0 = o_concl_m + o_concl_l;
        e0 = o_err_m + o_err_l;
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        tick(1'b1, 8'h44);
        tick(1'b1, 8'h55);
        idle(T + 2);
        n_vec++;
        if ((o_concl_m + o_concl_l - c0) != 0 || (o_err_m + o_err_l - e0) != 0) begin
            n_err++;
            $display("FAIL reset_midpkt_pulses: got concl %0d err %0d expected 0 0",
                     o_concl_m + o_concl_l - c0, o_err_m + o_err_l - e0);
        end
        n_vec++;
        if (buf_m !== '0 || cnt_m !== 8'd0 || rec_m !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midpkt_state: got buf %h cnt %0d rec %b expected 0 0 0",
                     buf_m, cnt_m, rec_m);
        end
    endtask

    task automatic test_counter_wrap();
        int c0;
        apply_reset(1);
        c0 = o_concl_m;
        for (int p = 0; p < 256; p++) begin
            tick(1'b1, EV);
            for (int b = 0; b < N; b++) tick(1'b1, 8'($urandom));
            if (p == 254) begin
                n_vec++;
                if (cnt_m !== 8'd255 || cnt_l !== 8'd255) begin
                    n_err++;
                    $display("FAIL count_255: got %0d/%0d expected 255", cnt_m, cnt_l);
                end
            end
        end
        n_vec++;
        if (cnt_m !== 8'd0 || cnt_l !== 8'd0 || cnt_m !== m_cnt) begin
            n_err++;
            $display("FAIL count_wrap: got %0d/%0d expected 0", cnt_m, cnt_l);
        end
        n_vec++;
        if ((o_concl_m - c0) != 256 || buf_m !== m_buf_m || buf_l !== m_buf_l) begin
            n_err++;
            $display("FAIL wrap_stream: got pulses %0d buf %h/%h expected 256 %h/%h",
                     o_concl_m - c0, buf_m, buf_l, m_buf_m, m_buf_l);
        end
    endtask

    task automatic test_random();
        int gap;
        for (int p = 0; p < 60; p++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                idle($urandom_range(0, 2));
                tick(1'b1, 8'($urandom));
            end
            tick(1'b1, EV);
            for (int b = 0; b < N; b++) begin
                gap = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 3, T) : $urandom_range(0, 3);
                idle(gap);
                tick(1'b1, ($urandom_range(0, 5) == 0) ? EV : 8'($urandom));
            end
            n_vec++;
            if (buf_m !== m_buf_m || buf_l !== m_buf_l || cnt_m !== m_cnt || cnt_l !== m_cnt
                || rec_m !== m_in_pkt || rec_l !== m_in_pkt) begin
                n_err++;
                $display("FAIL random_state pkt %0d: got buf %h/%h cnt %0d rec %b expected %h/%h %0d %b",
                         p, buf_m, buf_l, cnt_m, rec_m, m_buf_m, m_buf_l, m_cnt, m_in_pkt);
            end
            n_vec++;
            if (o_concl_m != m_concl_n || o_concl_l != m_concl_n || o_err_m != m_err_n
                || o_err_l != m_err_n) begin
                n_err++;
                $display("FAIL random_pulses pkt %0d: got concl %0d/%0d err %0d/%0d expected %0d %0d",
                         p, o_concl_m, o_concl_l, o_err_m, o_err_l, m_concl_n, m_err_n);
            end
        end
        n_vec++;
        if (o_both != 0) begin
            n_err++;
            $display("FAIL pulse_overlap: got %0d cycles expected 0", o_both);
        end
    endtask

    initial begin
        test_reset();
        test_spaced_packet();
        test_junk_back_to_back();
        test_timeout();
        test_timeout_boundary();
        test_header_payload_and_reset();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
